// File: rtl/la_deglitch.sv
// Synchronizing deglitch filter for slow asynchronous pad-level controls.
// A change on a is accepted only after cfg_hold+2 equal synchronized samples.
module la_deglitch #(
   parameter int SYNC     = 2,
   parameter int CW       = 8,
   parameter bit RESETVAL = 1'b0,
   parameter     PROP     = "DEFAULT"
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          a,
   input  logic          en,
   input  logic [CW-1:0] cfg_hold,
   output logic          z,
   output logic          rise,
   output logic          fall,
   output logic          busy
);

   localparam logic [0:0] STABLE  = 1'b0;
   localparam logic [0:0] QUALIFY = 1'b1;

   logic [SYNC-1:0] sync_q;
   logic            s;
   logic [0:0]      state;
   logic [CW-1:0]   cnt;

   // PROP only steers cell selection in mapped flows; every value behaves identically here.
   if (PROP == "") begin : g_prop_empty
   end

   // Synchronizer runs independently of en so s is always current on enable.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync_q <= {SYNC{RESETVAL}};
      end else begin
         sync_q <= {sync_q[SYNC-2:0], a};
      end
   end

   assign s    = sync_q[SYNC-1];
   assign busy = (state == QUALIFY);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state <= STABLE;
         cnt   <= '0;
         z     <= RESETVAL;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            STABLE: begin
               cnt <= '0;
               if (en && (s != z)) begin
                  state <= QUALIFY;
               end
            end
            QUALIFY: begin
               if (!en || (s == z)) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else if (cnt >= cfg_hold) begin
                  // >= lets a lowered threshold accept on the very next edge.
                  z     <= s;
                  rise  <= s;
                  fall  <= ~s;
                  state <= STABLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= STABLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_la_deglitch.sv
// Directed bench for la_deglitch: strobes are checked by a monitor against a
// queue of expected {edge, rise, fall, z} events; levels are checked inline.
module tb_la_deglitch;

   localparam int CW = 8;
   localparam int W  = 19;

   logic          clk;
   logic          clk_run;
   logic          nreset;
   logic          a;
   logic          en;
   logic [CW-1:0] cfg_hold;
   logic          z;
   logic          rise;
   logic          fall;
   logic          busy;

   int            cyc;
   int            n_cmp;
   int            n_fail;
   logic [W-1:0]  exp_q[$];

   la_deglitch #(
      .SYNC(2),
      .CW(CW),
      .RESETVAL(1'b0),
      .PROP("DEFAULT")
   ) dut (
      .clk(clk),
      .nreset(nreset),
      .a(a),
      .en(en),
      .cfg_hold(cfg_hold),
      .z(z),
      .rise(rise),
      .fall(fall),
      .busy(busy)
   );

   // clock / reset
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   // monitor: every strobe must match the head of the expected queue
   always @(negedge clk) begin
      logic [W-1:0] got;
      logic [W-1:0] e;
      if (rise || fall) begin
         got = {cyc[15:0], rise, fall, z};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL strobe_unexpected: cycle %0d rise=%b fall=%b z=%b, none expected",
                     cyc, rise, fall, z);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL strobe: got edge %0d rise=%b fall=%b z=%b, expected edge %0d rise=%b fall=%b z=%b",
                        got[18:3], got[2], got[1], got[0], e[18:3], e[2], e[1], e[0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: cycle %0d got %b expected %b", name, cyc, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ev(input int edge_n, input logic r, input logic f, input logic zz);
      logic [15:0] e16;
      e16 = 16'(edge_n);
      return {e16, r, f, zz};
   endfunction

   // Called right after a negedge: drive a level and follow a full qualify.
   task automatic qualify_run(input logic val, input int h);
      int k;
      a = val;
      k = cyc + 1;
      exp_q.push_back(ev(k + h + 3, val, ~val, val));
      for (int j = 0; j <= h + 4; j++) begin
         @(negedge clk);
         check("qual_busy", busy, (j >= 2 && j <= h + 2));
         check("qual_z", z, (j >= h + 3) ? val : ~val);
      end
   endtask

   initial begin
      int k;
      clk      = 1'b0;
      clk_run  = 1'b0;
      cyc      = 0;
      n_cmp    = 0;
      n_fail   = 0;
      nreset   = 1'b0;
      a        = 1'b1;
      en       = 1'b1;
      cfg_hold = 8'd3;

      // reset with the clock stopped
      #20;
      check("rst_z", z, 1'b0);
      check("rst_rise", rise, 1'b0);
      check("rst_fall", fall, 1'b0);
      check("rst_busy", busy, 1'b0);
      a       = 1'b0;
      clk_run = 1'b1;
      repeat (3) @(negedge clk);
      nreset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("post_rst_z", z, 1'b0);
         check("post_rst_busy", busy, 1'b0);
      end

      // accept rise and fall, H=3
      qualify_run(1'b1, 3);
      qualify_run(1'b0, 3);

      // reject a 4-cycle pulse, then accept a 5-cycle pulse (its trailing edge falls back)
      a = 1'b1;
      k = cyc + 1;
      for (int j = 0; j <= 8; j++) begin
         @(negedge clk);
         check("rej_busy", busy, (j >= 2 && j <= 5));
         check("rej_z", z, 1'b0);
         if (j == 3) a = 1'b0;
      end
      a = 1'b1;
      k = cyc + 1;
      exp_q.push_back(ev(k + 6, 1'b1, 1'b0, 1'b1));
      exp_q.push_back(ev(k + 11, 1'b0, 1'b1, 1'b0));
      for (int j = 0; j <= 12; j++) begin
         @(negedge clk);
         check("p5_busy", busy, (j >= 2 && j <= 5) || (j >= 7 && j <= 10));
         check("p5_z", z, (j >= 6 && j <= 10));
         if (j == 4) a = 1'b0;
      end

      // zero hold
      cfg_hold = 8'd0;
      qualify_run(1'b1, 0);
      qualify_run(1'b0, 0);

      // live threshold lowered mid-qualify
      cfg_hold = 8'd200;
      a = 1'b1;
      k = cyc + 1;
      exp_q.push_back(ev(k + 12, 1'b1, 1'b0, 1'b1));
      for (int j = 0; j <= 13; j++) begin
         @(negedge clk);
         check("live_busy", busy, (j >= 2 && j <= 11));
         check("live_z", z, (j >= 12));
         if (j == 11) cfg_hold = 8'd5;
      end
      cfg_hold = 8'd3;
      qualify_run(1'b0, 3);

      // enable gating: drop en mid-qualify, then restart from zero
      a = 1'b1;
      k = cyc + 1;
      exp_q.push_back(ev(k + 11, 1'b1, 1'b0, 1'b1));
      for (int j = 0; j <= 12; j++) begin
         @(negedge clk);
         check("en_busy", busy, (j >= 2 && j <= 3) || (j >= 7 && j <= 10));
         check("en_z", z, (j >= 11));
         if (j == 3) en = 1'b0;
         if (j == 6) en = 1'b1;
      end
      qualify_run(1'b0, 3);

      // async reset while a fall is being qualified
      qualify_run(1'b1, 3);
      a = 1'b0;
      for (int j = 0; j <= 3; j++) begin
         @(negedge clk);
      end
      check("pre_arst_busy", busy, 1'b1);
      check("pre_arst_z", z, 1'b1);
      a = 1'b1;
      #2;
      nreset = 1'b0;
      #1;
      check("arst_z", z, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_rise", rise, 1'b0);
      check("arst_fall", fall, 1'b0);
      @(negedge clk);
      nreset = 1'b1;
      qualify_run(1'b1, 3);

      repeat (10) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL strobe_missing: %0d expected strobes never seen, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
